// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam int MAX_DATA_BITS = 9;

  // Callers zero-extend narrower words, which leaves the parity of the real bits unchanged.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data, input parity_e parity);
    case (parity)
      PAR_ODD:  return ~^data;
      PAR_EVEN: return ^data;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_fifo_param_sync_fifo.sv
// Synchronous FIFO with extra-bit pointers; dout shows the head entry whenever not empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter with valid/ready intake.
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry FIFO in front of the frame FSM.
module uart_tx_fifo_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_BITS-1:0] s_data,
  output logic                 txd,
  output logic                 active,
  output logic                 done
);

  localparam int                BIT_W      = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0]  LAST_BIT   = BIT_W'(DATA_BITS - 1);
  localparam logic              LAST_STOP  = (STOP_BITS == 2);
  localparam bit                HAS_PARITY = (PARITY != 0);
  localparam parity_e           PAR_CFG    = parity_e'(PARITY[1:0]);

  if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
    $error("uart_tx_fifo_param: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo_param: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("uart_tx_fifo_param: FIFO_DEPTH must be a power of two >= 2");
  end

  tx_state_e            state;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_q;
  logic [DIV_W-1:0]     div_q;
  logic [DIV_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 stop_cnt;
  logic                 ready_q;   // FSM can start a frame: high only in IDLE
  logic                 take;
  logic [DATA_BITS-1:0] word_in;

`ifdef UART_TX_FIFO_EN
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_dout;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s_valid && s_ready),
    .din   (s_data),
    .full  (fifo_full),
    .pop   (take),
    .dout  (fifo_dout),
    .empty (fifo_empty)
  );

  // A word pushed into an empty FIFO is only seen by the FSM on the following cycle.
  assign s_ready = !rst && !fifo_full;
  assign take    = ready_q && !fifo_empty;
  assign word_in = fifo_dout;
`else
  assign s_ready = ready_q;
  assign take    = ready_q && s_valid;
  assign word_in = s_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      par_q    <= 1'b0;
      div_q    <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      ready_q  <= 1'b0;
      txd      <= 1'b1;
      active   <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) begin
        ready_q <= !take;
        if (take) begin
          state    <= ST_START;
          shreg    <= word_in;
          par_q    <= calc_parity(MAX_DATA_BITS'(word_in), PAR_CFG);
          div_q    <= baud_div;
          baud_cnt <= '0;
          txd      <= 1'b0;
          active   <= 1'b1;
        end
      end else if (baud_cnt != div_q) begin
        baud_cnt <= baud_cnt + 1'b1;
      end else begin
        // End of a bit period: choose the next line level.
        baud_cnt <= '0;
        case (state)
          ST_START: begin
            state   <= ST_DATA;
            bit_cnt <= '0;
            txd     <= shreg[0];
          end
          ST_DATA: begin
            if (bit_cnt != LAST_BIT) begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= shreg >> 1;
              txd     <= shreg[1];
            end else if (HAS_PARITY) begin
              state <= ST_PARITY;
              txd   <= par_q;
            end else begin
              state    <= ST_STOP;
              stop_cnt <= 1'b0;
              txd      <= 1'b1;
            end
          end
          ST_PARITY: begin
            state    <= ST_STOP;
            stop_cnt <= 1'b0;
            txd      <= 1'b1;
          end
          ST_STOP: begin
            if (stop_cnt != LAST_STOP) begin
              stop_cnt <= 1'b1;
            end else begin
              state   <= ST_IDLE;
              txd     <= 1'b1;
              active  <= 1'b0;
              done    <= 1'b1;
              ready_q <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
